// File: rtl/dlx_pkg.sv
// Shared DLX decode/issue definitions: opcode and func codes, ALU op enum, decode record.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package dlx_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int RAW   = 5;   // register address width

  // Primary opcodes, instr[31:26]
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_BEQZ  = 6'h04;
  localparam logic [5:0] OPC_BNEZ  = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SUBI  = 6'h0A;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_SLLI  = 6'h14;
  localparam logic [5:0] OPC_SRLI  = 6'h16;
  localparam logic [5:0] OPC_SEQI  = 6'h18;
  localparam logic [5:0] OPC_SNEI  = 6'h19;
  localparam logic [5:0] OPC_SLTI  = 6'h1A;
  localparam logic [5:0] OPC_SLEI  = 6'h1C;

  // R-type function codes, instr[5:0]
  localparam logic [5:0] FN_SLL  = 6'h04;
  localparam logic [5:0] FN_SRL  = 6'h06;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SEQ  = 6'h28;
  localparam logic [5:0] FN_SNE  = 6'h29;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLE  = 6'h2C;

  typedef enum logic [3:0] {
    ALU_NOP  = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_BEQZ = 4'd8,
    ALU_BNEZ = 4'd9,
    ALU_SEQ  = 4'd10,
    ALU_SLE  = 4'd11,
    ALU_SLT  = 4'd12,
    ALU_SNE  = 4'd13
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    use_rs2;   // R-type: rs2 is a real source
    logic    imm_zext;  // logical immediates are zero-extended
    logic    wb_en;     // writes a destination (before the r0 check)
    logic    branch;
    logic    illegal;
  } dec_t;

endpackage

// File: rtl/dlx_scoreboard.sv
// Busy bit per architectural register, set by issue and cleared by writeback; r0 never busy.
// Latency: set/clear visible the cycle after the edge; lookups are combinational on the stored bits.
// Backpressure: none; the issue stage uses the lookups to stall itself.
module dlx_scoreboard #(
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  output logic          rs1_busy,
  output logic          rs2_busy
);

  logic [NREGS-1:0] busy;

  // Per-register update; a same-cycle set beats a clear since the newer writer owns the register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (set_en && (set_addr == AW'(i))) begin
          busy[i] <= 1'b1;
        end else if (clr_en && (clr_addr == AW'(i))) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

  // No bypass of this cycle's clear: a source retiring now still reads busy
  assign rs1_busy = busy[rs1_addr];
  assign rs2_busy = busy[rs2_addr];

endmodule

// File: rtl/dlx_decode_issue.sv
// DLX decode/issue: decodes one instruction per handshake, builds operands, issues a registered ALU command.
// Latency: accepted in cycle N, ALU command and flags valid in cycle N+1.
// Backpressure: in_ready drops combinationally while any used source register is busy in the scoreboard.
module dlx_decode_issue
  import dlx_pkg::*;
#(
  parameter int XLEN  = dlx_pkg::XLEN,
  parameter int NREGS = dlx_pkg::NREGS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic [4:0]      rf_rs1_addr,
  output logic [4:0]      rf_rs2_addr,
  input  logic [XLEN-1:0] rf_rs1_data,
  input  logic [XLEN-1:0] rf_rs2_data,
  input  logic            wb_valid,
  input  logic [4:0]      wb_addr,
  input  logic            flush,
  output logic [3:0]      alu_I,
  output logic            alu_EX,
  output logic [XLEN-1:0] alu_op1,
  output logic [XLEN-1:0] alu_op2,
  output logic [4:0]      out_rd,
  output logic            out_wb_en,
  output logic            out_branch,
  output logic            illegal
);

  function automatic dec_t decode(input logic [31:0] w);
    dec_t d;
    d.alu_op   = ALU_NOP;
    d.use_rs2  = 1'b0;
    d.imm_zext = 1'b0;
    d.wb_en    = 1'b1;
    d.branch   = 1'b0;
    d.illegal  = 1'b0;
    case (w[31:26])
      OPC_RTYPE: begin
        d.use_rs2 = 1'b1;
        case (w[5:0])
          FN_ADD, FN_ADDU: d.alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: d.alu_op = ALU_SUB;
          FN_AND:          d.alu_op = ALU_AND;
          FN_OR:           d.alu_op = ALU_OR;
          FN_XOR:          d.alu_op = ALU_XOR;
          FN_SLL:          d.alu_op = ALU_SLL;
          FN_SRL:          d.alu_op = ALU_SRL;
          FN_SEQ:          d.alu_op = ALU_SEQ;
          FN_SNE:          d.alu_op = ALU_SNE;
          FN_SLT:          d.alu_op = ALU_SLT;
          FN_SLE:          d.alu_op = ALU_SLE;
          default:         d.illegal = 1'b1;
        endcase
      end
      OPC_ADDI: d.alu_op = ALU_ADD;
      OPC_SUBI: d.alu_op = ALU_SUB;
      OPC_ANDI: begin d.alu_op = ALU_AND; d.imm_zext = 1'b1; end
      OPC_ORI:  begin d.alu_op = ALU_OR;  d.imm_zext = 1'b1; end
      OPC_XORI: begin d.alu_op = ALU_XOR; d.imm_zext = 1'b1; end
      OPC_SLLI: d.alu_op = ALU_SLL;
      OPC_SRLI: d.alu_op = ALU_SRL;
      OPC_SEQI: d.alu_op = ALU_SEQ;
      OPC_SNEI: d.alu_op = ALU_SNE;
      OPC_SLTI: d.alu_op = ALU_SLT;
      OPC_SLEI: d.alu_op = ALU_SLE;
      OPC_BEQZ: begin d.alu_op = ALU_BEQZ; d.wb_en = 1'b0; d.branch = 1'b1; end
      OPC_BNEZ: begin d.alu_op = ALU_BNEZ; d.wb_en = 1'b0; d.branch = 1'b1; end
      default:  d.illegal = 1'b1;
    endcase
    if (d.illegal) begin
      d.alu_op  = ALU_NOP;
      d.use_rs2 = 1'b0;
      d.wb_en   = 1'b0;
    end
    return d;
  endfunction

  dec_t            dec;
  logic [4:0]      rd;
  logic            wb_en;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            accept;
  logic            issue;
  logic [15:0]     imm;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;

  assign rf_rs1_addr = in_instr[25:21];
  assign rf_rs2_addr = in_instr[20:16];
  assign dec         = decode(in_instr);

  // R-type writes [15:11]; I-type writes [20:16]; r0 as destination is discarded
  assign rd    = dec.use_rs2 ? in_instr[15:11] : in_instr[20:16];
  assign wb_en = dec.wb_en & (rd != 5'd0);

  // rs1 is always a source; rs2 only for R-type, so an I-type rd field never stalls
  assign in_ready = ~(rs1_busy | (dec.use_rs2 & rs2_busy));
  assign accept   = in_valid & in_ready;
  assign issue    = accept & ~flush & ~dec.illegal;

  assign imm     = in_instr[15:0];
  assign imm_ext = dec.imm_zext ? {{(XLEN-16){1'b0}}, imm} : {{(XLEN-16){imm[15]}}, imm};
  assign op1     = (rf_rs1_addr == 5'd0) ? '0 : rf_rs1_data;
  assign op2     = dec.use_rs2 ? ((rf_rs2_addr == 5'd0) ? '0 : rf_rs2_data) : imm_ext;

  dlx_scoreboard #(
    .NREGS (NREGS),
    .AW    (5)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (issue & wb_en),
    .set_addr (rd),
    .clr_en   (wb_valid),
    .clr_addr (wb_addr),
    .rs1_addr (rf_rs1_addr),
    .rs2_addr (rf_rs2_addr),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy)
  );

  // Output bank: a real issue loads the command, everything else (stall, flush, illegal) is an all-zero bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_I      <= 4'd0;
      alu_EX     <= 1'b0;
      alu_op1    <= '0;
      alu_op2    <= '0;
      out_rd     <= 5'd0;
      out_wb_en  <= 1'b0;
      out_branch <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      alu_EX  <= issue;
      illegal <= accept & ~flush & dec.illegal;
      if (issue) begin
        alu_I      <= dec.alu_op;
        alu_op1    <= op1;
        alu_op2    <= op2;
        out_rd     <= rd;
        out_wb_en  <= wb_en;
        out_branch <= dec.branch;
      end else begin
        alu_I      <= 4'd0;
        alu_op1    <= '0;
        alu_op2    <= '0;
        out_rd     <= 5'd0;
        out_wb_en  <= 1'b0;
        out_branch <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dlx_decode_issue.sv
// Bench for dlx_decode_issue: directed scenarios followed by randomized traffic against a table-driven model.
// Latency: expects each accepted instruction's command one cycle after acceptance.
// Backpressure: holds a stalled instruction until accepted; writebacks are aimed at busy sources.
module tb_dlx_decode_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = 32'h0;
  logic [4:0]  rf_rs1_addr;
  logic [4:0]  rf_rs2_addr;
  logic [31:0] rf_rs1_data;
  logic [31:0] rf_rs2_data;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_addr = 5'd0;
  logic        flush = 1'b0;
  logic [3:0]  alu_I;
  logic        alu_EX;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [4:0]  out_rd;
  logic        out_wb_en;
  logic        out_branch;
  logic        illegal;

  dlx_decode_issue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .rf_rs1_addr (rf_rs1_addr),
    .rf_rs2_addr (rf_rs2_addr),
    .rf_rs1_data (rf_rs1_data),
    .rf_rs2_data (rf_rs2_data),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .flush       (flush),
    .alu_I       (alu_I),
    .alu_EX      (alu_EX),
    .alu_op1     (alu_op1),
    .alu_op2     (alu_op2),
    .out_rd      (out_rd),
    .out_wb_en   (out_wb_en),
    .out_branch  (out_branch),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  // Behavioural register file
  logic [31:0] regs [32];
  assign rf_rs1_data = regs[rf_rs1_addr];
  assign rf_rs2_data = regs[rf_rs2_addr];

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: per-register busy flags and opcode/func -> ALU op tables (0 = illegal)
  bit mbusy [32];
  int r_map [64];
  int i_map [64];
  bit last_acc;

  logic [5:0] fn_list  [12] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                6'h26, 6'h04, 6'h06, 6'h28, 6'h29, 6'h2A};
  logic [5:0] opc_list [13] = '{6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h14, 6'h16,
                                6'h18, 6'h19, 6'h1A, 6'h1C, 6'h04, 6'h05};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] r_ins(input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs1, rs2, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] opc, input logic [4:0] rs1,
                                        input logic [4:0] rd, input logic [15:0] imm);
    return {opc, rs1, rd, imm};
  endfunction

  function automatic int op_of(input logic [31:0] w);
    return (w[31:26] == 6'h00) ? r_map[w[5:0]] : i_map[w[31:26]];
  endfunction

  function automatic bit stalls(input logic [31:0] w);
    return mbusy[w[25:21]] || ((w[31:26] == 6'h00) && mbusy[w[20:16]]);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0] a, b, c;
    int sel;
    a = 5'($urandom_range(0, 7));
    b = 5'($urandom_range(0, 7));
    c = 5'($urandom_range(0, 7));
    sel = $urandom_range(0, 9);
    if (sel < 4) return r_ins(a, b, c, fn_list[$urandom_range(0, 11)]);
    if (sel < 9) return i_ins(opc_list[$urandom_range(0, 12)], a, b, 16'($urandom));
    return $urandom;
  endfunction

  // One clock: drive at negedge, check in_ready, predict, then check registered outputs after posedge
  task automatic cyc(input bit v, input logic [31:0] w, input bit wv, input logic [4:0] wa, input bit fl);
    bit          exp_rdy, acc, rt, br, e_ex, e_ill, e_wb;
    int          op;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [31:0] e_op1, e_op2;
    @(negedge clk);
    in_valid = v; in_instr = w; wb_valid = wv; wb_addr = wa; flush = fl;
    #1;
    exp_rdy = !stalls(w);
    chk("in_ready", in_ready, exp_rdy);
    chk("rs1_addr", rf_rs1_addr, w[25:21]);
    chk("rs2_addr", rf_rs2_addr, w[20:16]);
    acc   = v && exp_rdy;
    op    = op_of(w);
    rt    = (w[31:26] == 6'h00);
    br    = (w[31:26] == 6'h04) || (w[31:26] == 6'h05);
    rd    = rt ? w[15:11] : w[20:16];
    imm   = w[15:0];
    e_ex  = acc && (op != 0) && !fl;
    e_ill = acc && (op == 0) && !fl;
    e_wb  = !br && (rd != 5'd0);
    e_op1 = (w[25:21] == 5'd0) ? 32'h0 : regs[w[25:21]];
    if (rt)
      e_op2 = (w[20:16] == 5'd0) ? 32'h0 : regs[w[20:16]];
    else if ((w[31:26] == 6'h0C) || (w[31:26] == 6'h0D) || (w[31:26] == 6'h0E))
      e_op2 = {16'h0000, imm};
    else
      e_op2 = {{16{imm[15]}}, imm};
    if (wv) mbusy[wa] = 1'b0;
    if (e_ex && e_wb) mbusy[rd] = 1'b1;
    last_acc = acc;
    @(posedge clk);
    #1;
    chk("alu_EX", alu_EX, e_ex);
    chk("alu_I", alu_I, e_ex ? 32'(op) : 32'h0);
    chk("illegal", illegal, e_ill);
    if (e_ex) begin
      chk("alu_op1", alu_op1, e_op1);
      chk("alu_op2", alu_op2, e_op2);
      chk("out_rd", out_rd, rd);
      chk("out_wb_en", out_wb_en, e_wb);
      chk("out_branch", out_branch, br);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_alu_I"}, alu_I, 32'h0);
    chk({tag, "_alu_EX"}, alu_EX, 32'h0);
    chk({tag, "_op1"}, alu_op1, 32'h0);
    chk({tag, "_op2"}, alu_op2, 32'h0);
    chk({tag, "_rd"}, out_rd, 32'h0);
    chk({tag, "_wb_en"}, out_wb_en, 32'h0);
    chk({tag, "_branch"}, out_branch, 32'h0);
    chk({tag, "_illegal"}, illegal, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] w, sub_w;
    bit          v, held, wv, fl;
    logic [4:0]  wa;

    for (int i = 0; i < 64; i++) begin r_map[i] = 0; i_map[i] = 0; end
    r_map[6'h20] = 1; r_map[6'h21] = 1; r_map[6'h22] = 2; r_map[6'h23] = 2;
    r_map[6'h24] = 3; r_map[6'h25] = 4; r_map[6'h26] = 5; r_map[6'h04] = 6;
    r_map[6'h06] = 7; r_map[6'h28] = 10; r_map[6'h29] = 13; r_map[6'h2A] = 12;
    r_map[6'h2C] = 11;
    i_map[6'h08] = 1; i_map[6'h0A] = 2; i_map[6'h0C] = 3; i_map[6'h0D] = 4;
    i_map[6'h0E] = 5; i_map[6'h14] = 6; i_map[6'h16] = 7; i_map[6'h18] = 10;
    i_map[6'h19] = 13; i_map[6'h1A] = 12; i_map[6'h1C] = 11; i_map[6'h04] = 8;
    i_map[6'h05] = 9;
    for (int i = 0; i < 32; i++) begin regs[i] = $urandom; mbusy[i] = 1'b0; end
    regs[0] = 32'hDEAD_BEEF;  // must never reach an operand
    regs[1] = 32'd5;
    regs[2] = 32'd7;

    // Reset state
    #3;
    chk_all_zero("reset");
    chk("reset_in_ready", in_ready, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD r3,r1,r2
    cyc(1, r_ins(5'd1, 5'd2, 5'd3, 6'h20), 0, 5'd0, 0);
    chk("add_I", alu_I, 32'd1);
    chk("add_op1", alu_op1, 32'd5);
    chk("add_op2", alu_op2, 32'd7);
    chk("add_rd", out_rd, 32'd3);
    chk("add_wb_en", out_wb_en, 32'd1);

    // SUB r5,r3,r1 stalls on r3; clear cycle still stalls; accepted the cycle after
    sub_w = r_ins(5'd3, 5'd1, 5'd5, 6'h22);
    cyc(1, sub_w, 0, 5'd0, 0);
    chk("sub_stall", alu_EX, 32'h0);
    cyc(1, sub_w, 1, 5'd3, 0);
    cyc(1, sub_w, 0, 5'd0, 0);
    chk("sub_issue_I", alu_I, 32'd2);
    cyc(0, 32'h0, 1, 5'd5, 0);

    // Immediate extension
    cyc(1, i_ins(6'h08, 5'd0, 5'd4, 16'h8000), 0, 5'd0, 0);
    chk("addi_op2", alu_op2, 32'hFFFF_8000);
    cyc(1, i_ins(6'h0C, 5'd0, 5'd4, 16'h8000), 1, 5'd4, 0);
    chk("andi_op2", alu_op2, 32'h0000_8000);
    chk("andi_I", alu_I, 32'd3);
    cyc(0, 32'h0, 1, 5'd4, 0);

    // Branch: no writeback, branch flag
    cyc(1, i_ins(6'h05, 5'd2, 5'd9, 16'hFFFC), 0, 5'd0, 0);
    chk("bnez_I", alu_I, 32'd9);
    chk("bnez_branch", out_branch, 32'h1);
    chk("bnez_wb_en", out_wb_en, 32'h0);

    // Illegal word, then a normal ADD
    cyc(1, 32'hFC00_0000, 0, 5'd0, 0);
    chk("illegal_strobe", illegal, 32'h1);
    chk("illegal_EX", alu_EX, 32'h0);
    cyc(1, r_ins(5'd1, 5'd2, 5'd7, 6'h20), 0, 5'd0, 0);
    chk("post_illegal_EX", alu_EX, 32'h1);
    cyc(0, 32'h0, 1, 5'd7, 0);

    // Same-cycle clear and set of r6: set wins, reader stalls
    cyc(1, i_ins(6'h08, 5'd1, 5'd6, 16'h0001), 1, 5'd6, 0);
    cyc(1, r_ins(5'd6, 5'd1, 5'd8, 6'h20), 0, 5'd0, 0);
    chk("r6_reader_stall", in_ready, 32'h0);
    cyc(0, 32'h0, 1, 5'd6, 0);

    // Flushed writer leaves no busy bit behind
    cyc(1, r_ins(5'd1, 5'd2, 5'd10, 6'h24), 0, 5'd0, 1);
    cyc(1, r_ins(5'd10, 5'd1, 5'd11, 6'h20), 0, 5'd0, 0);
    cyc(0, 32'h0, 1, 5'd11, 0);

    // Async reset in the middle of a stall
    cyc(1, r_ins(5'd1, 5'd2, 5'd3, 6'h20), 0, 5'd0, 0);
    in_valid = 1'b1; in_instr = sub_w; wb_valid = 1'b0;
    #2;
    chk("pre_reset_stall", in_ready, 32'h0);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    chk("async_rst_in_ready", in_ready, 32'h1);
    for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, sub_w, 0, 5'd0, 0);
    chk("post_rst_sub_EX", alu_EX, 32'h1);
    cyc(0, 32'h0, 1, 5'd5, 0);

    // Randomized traffic with held stalled instructions
    held = 1'b0;
    v = 1'b0;
    w = 32'h0;
    for (int k = 0; k < 3000; k++) begin
      if (!held) begin
        v = ($urandom_range(0, 3) != 0);
        w = rand_instr();
      end
      fl = ($urandom_range(0, 15) == 0) && (op_of(w) != 0);
      wv = ($urandom_range(0, 2) == 0);
      if (stalls(w) && ($urandom_range(0, 1) == 1))
        wa = mbusy[w[25:21]] ? w[25:21] : w[20:16];
      else
        wa = 5'($urandom_range(0, 9));
      cyc(v, w, wv, wa, fl);
      held = v && !last_acc;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
